// File: rtl/sap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sap_ctrl_pkg                                                     |
// | Brief   : Opcodes, control-word bit indices/masks and helpers for the      |
// |           SAP-style control sequencer.                                     |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sap_ctrl_pkg;

  localparam logic [3:0] c_op_nop = 4'b0000;
  localparam logic [3:0] c_op_lda = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0011;
  localparam logic [3:0] c_op_sta = 4'b0100;
  localparam logic [3:0] c_op_ldi = 4'b0101;
  localparam logic [3:0] c_op_jmp = 4'b0110;
  localparam logic [3:0] c_op_jc  = 4'b0111;
  localparam logic [3:0] c_op_jz  = 4'b1000;
  localparam logic [3:0] c_op_out = 4'b1110;
  localparam logic [3:0] c_op_hlt = 4'b1111;

  localparam int unsigned c_bit_halt     = 15;
  localparam int unsigned c_bit_mar_in   = 14;
  localparam int unsigned c_bit_ram_in   = 13;
  localparam int unsigned c_bit_ram_out  = 12;
  localparam int unsigned c_bit_ir_out   = 11;
  localparam int unsigned c_bit_ir_in    = 10;
  localparam int unsigned c_bit_a_in     = 9;
  localparam int unsigned c_bit_a_out    = 8;
  localparam int unsigned c_bit_sum_out  = 7;
  localparam int unsigned c_bit_subtract = 6;
  localparam int unsigned c_bit_b_in     = 5;
  localparam int unsigned c_bit_out_in   = 4;
  localparam int unsigned c_bit_pc_en    = 3;
  localparam int unsigned c_bit_pc_out   = 2;
  localparam int unsigned c_bit_jump     = 1;
  localparam int unsigned c_bit_flags_in = 0;

  localparam logic [15:0] c_halt     = 16'h0001 << c_bit_halt;
  localparam logic [15:0] c_mar_in   = 16'h0001 << c_bit_mar_in;
  localparam logic [15:0] c_ram_in   = 16'h0001 << c_bit_ram_in;
  localparam logic [15:0] c_ram_out  = 16'h0001 << c_bit_ram_out;
  localparam logic [15:0] c_ir_out   = 16'h0001 << c_bit_ir_out;
  localparam logic [15:0] c_ir_in    = 16'h0001 << c_bit_ir_in;
  localparam logic [15:0] c_a_in     = 16'h0001 << c_bit_a_in;
  localparam logic [15:0] c_a_out    = 16'h0001 << c_bit_a_out;
  localparam logic [15:0] c_sum_out  = 16'h0001 << c_bit_sum_out;
  localparam logic [15:0] c_subtract = 16'h0001 << c_bit_subtract;
  localparam logic [15:0] c_b_in     = 16'h0001 << c_bit_b_in;
  localparam logic [15:0] c_out_in   = 16'h0001 << c_bit_out_in;
  localparam logic [15:0] c_pc_en    = 16'h0001 << c_bit_pc_en;
  localparam logic [15:0] c_pc_out   = 16'h0001 << c_bit_pc_out;
  localparam logic [15:0] c_jump     = 16'h0001 << c_bit_jump;
  localparam logic [15:0] c_flags_in = 16'h0001 << c_bit_flags_in;

  // Last microstep carrying a non-zero control word; NOPs and jumps end at T2.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      c_op_lda, c_op_sta: last_step = 3'd3;
      c_op_add, c_op_sub: last_step = 3'd4;
      default:            last_step = 3'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : microcode_rom                                                    |
// | Brief   : Combinational decode of (step, opcode, flags) to control word.   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module microcode_rom
  import sap_ctrl_pkg::*;
(
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl
);

  always_comb begin
    ctrl = 16'h0000;
    case (step)
      3'd0: ctrl = c_pc_out | c_mar_in;
      3'd1: ctrl = c_ram_out | c_ir_in | c_pc_en;
      3'd2: begin
        case (opcode)
          c_op_lda, c_op_add, c_op_sub, c_op_sta: ctrl = c_ir_out | c_mar_in;
          c_op_ldi: ctrl = c_ir_out | c_a_in;
          c_op_jmp: ctrl = c_ir_out | c_jump;
          c_op_jc:  ctrl = carry_flag ? (c_ir_out | c_jump) : 16'h0000;
          c_op_jz:  ctrl = zero_flag  ? (c_ir_out | c_jump) : 16'h0000;
          c_op_out: ctrl = c_a_out | c_out_in;
          c_op_hlt: ctrl = c_halt;
          default:  ctrl = 16'h0000;
        endcase
      end
      3'd3: begin
        case (opcode)
          c_op_lda:           ctrl = c_ram_out | c_a_in;
          c_op_add, c_op_sub: ctrl = c_ram_out | c_b_in;
          c_op_sta:           ctrl = c_a_out | c_ram_in;
          default:            ctrl = 16'h0000;
        endcase
      end
      3'd4: begin
        case (opcode)
          c_op_add: ctrl = c_sum_out | c_a_in | c_flags_in;
          c_op_sub: ctrl = c_sum_out | c_a_in | c_flags_in | c_subtract;
          default:  ctrl = 16'h0000;
        endcase
      end
      default: ctrl = 16'h0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : control_sequencer                                                |
// | Brief   : Microstep counter and halt latch driving microcode_rom.          |
// |           Define CTRL_SEQ_EARLY_END_EN to end each instruction after its   |
// |           last non-zero microstep.                                         |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] c_final_step = 3'(NUM_STEPS - 1);

  logic [2:0]  r_step;
  logic        r_halted;
  logic        w_end;
  logic [2:0]  w_step_next;
  logic [15:0] w_rom_ctrl;

  always_comb begin
    w_end = (r_step == c_final_step);
`ifdef CTRL_SEQ_EARLY_END_EN
    w_end = w_end || (r_step == last_step(opcode));
`endif
    w_step_next = w_end ? 3'd0 : (r_step + 3'd1);
  end

  // Halting keeps the counter parked on T2 instead of advancing.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else if (run && !r_halted) begin
      if (r_step == 3'd2 && opcode == c_op_hlt) begin
        r_halted <= 1'b1;
      end else begin
        r_step <= w_step_next;
      end
    end
  end

  microcode_rom u_rom (
    .step       (r_step),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (w_rom_ctrl)
  );

  // clear gates the word directly so it reads zero while held, not just after.
  assign ctrl   = clear ? 16'h0000 : (r_halted ? c_halt : w_rom_ctrl);
  assign step   = r_step;
  assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_control_sequencer                                             |
// | Brief   : Directed self-checking bench for control_sequencer.              |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        carry_flag = 1'b0;
  logic        zero_flag = 1'b0;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int total = 0;
  int bad = 0;

  control_sequencer #(.NUM_STEPS(5)) dut (
    .clk        (clk),
    .clear      (clear),
    .run        (run),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (ctrl),
    .step       (step),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #1;
    clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (step !== 3'd0 || ctrl !== 16'h0000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold step=%0d ctrl=%h halted=%b want 0/0000/0", step, ctrl, halted);
    end
    clear = 1'b0;
    #1;
    total++;
    if (ctrl !== 16'h4004 || step !== 3'd0) begin
      bad++;
      $display("FAIL reset_release ctrl=%h step=%0d want 4004/0", ctrl, step);
    end
  endtask

  task automatic test_add();
    logic [15:0] exp_ctrl [6] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h4004};
    logic [2:0]  exp_step [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    pulse_clear();
    opcode = 4'b0010;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (ctrl !== exp_ctrl[i] || step !== exp_step[i]) begin
        bad++;
        $display("FAIL add_seq[%0d] ctrl=%h step=%0d want %h/%0d", i, ctrl, step, exp_ctrl[i], exp_step[i]);
      end
      if (i < 5) tick(1);
    end
  endtask

  task automatic test_sub_lda();
    pulse_clear();
    opcode = 4'b0011;
    tick(4);
    total++;
    if (ctrl !== 16'h02C1) begin
      bad++;
      $display("FAIL sub_t4 ctrl=%h want 02c1", ctrl);
    end
    pulse_clear();
    opcode = 4'b0001;
    tick(2);
    total++;
    if (ctrl !== 16'h4800) begin
      bad++;
      $display("FAIL lda_t2 ctrl=%h want 4800", ctrl);
    end
    tick(1);
    total++;
    if (ctrl !== 16'h1200) begin
      bad++;
      $display("FAIL lda_t3 ctrl=%h want 1200", ctrl);
    end
    tick(1);
`ifdef CTRL_SEQ_EARLY_END_EN
    total++;
    if (step !== 3'd0 || ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL lda_end step=%0d ctrl=%h want 0/4004", step, ctrl);
    end
`else
    total++;
    if (step !== 3'd4 || ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL lda_t4 step=%0d ctrl=%h want 4/0000", step, ctrl);
    end
`endif
  endtask

  task automatic test_t2_table();
    logic [3:0]  ops [6]  = '{4'b0101, 4'b0110, 4'b1110, 4'b0000, 4'b1001, 4'b1101};
    logic [15:0] want [6] = '{16'h0A00, 16'h0802, 16'h0110, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      pulse_clear();
      opcode = ops[i];
      tick(2);
      total++;
      if (ctrl !== want[i] || step !== 3'd2) begin
        bad++;
        $display("FAIL t2_op%h ctrl=%h step=%0d want %h/2", ops[i], ctrl, step, want[i]);
      end
    end
  endtask

  task automatic test_cond_jump();
    pulse_clear();
    opcode = 4'b0111;
    carry_flag = 1'b1;
    zero_flag = 1'b0;
    tick(2);
    total++;
    if (ctrl !== 16'h0802) begin
      bad++;
      $display("FAIL jc_taken ctrl=%h want 0802", ctrl);
    end
    carry_flag = 1'b0;
    #1;
    total++;
    if (ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL jc_untaken ctrl=%h want 0000", ctrl);
    end
    tick(1);
`ifdef CTRL_SEQ_EARLY_END_EN
    total++;
    if (step !== 3'd0) begin
      bad++;
      $display("FAIL jc_early_end step=%0d want 0", step);
    end
`else
    total++;
    if (step !== 3'd3) begin
      bad++;
      $display("FAIL jc_full_len step=%0d want 3", step);
    end
`endif
    pulse_clear();
    opcode = 4'b1000;
    carry_flag = 1'b1;
    tick(2);
    total++;
    if (ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL jz_untaken ctrl=%h want 0000", ctrl);
    end
    zero_flag = 1'b1;
    #1;
    total++;
    if (ctrl !== 16'h0802) begin
      bad++;
      $display("FAIL jz_taken ctrl=%h want 0802", ctrl);
    end
    carry_flag = 1'b0;
    zero_flag = 1'b0;
  endtask

  task automatic test_run_hold();
    pulse_clear();
    opcode = 4'b0100;
    tick(3);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if (step !== 3'd3 || ctrl !== 16'h2100) begin
        bad++;
        $display("FAIL sta_hold[%0d] step=%0d ctrl=%h want 3/2100", i, step, ctrl);
      end
    end
    run = 1'b1;
    tick(1);
`ifdef CTRL_SEQ_EARLY_END_EN
    total++;
    if (step !== 3'd0) begin
      bad++;
      $display("FAIL sta_resume step=%0d want 0", step);
    end
`else
    total++;
    if (step !== 3'd4 || ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL sta_resume step=%0d ctrl=%h want 4/0000", step, ctrl);
    end
`endif
  endtask

  task automatic test_clear_mid_add();
    pulse_clear();
    opcode = 4'b0010;
    tick(3);
    clear = 1'b1;
    #1;
    total++;
    if (step !== 3'd0 || ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL clear_async step=%0d ctrl=%h want 0/0000", step, ctrl);
    end
    tick(2);
    total++;
    if (step !== 3'd0 || ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL clear_held step=%0d ctrl=%h want 0/0000", step, ctrl);
    end
    clear = 1'b0;
    #1;
    total++;
    if (step !== 3'd0 || ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL clear_release step=%0d ctrl=%h want 0/4004", step, ctrl);
    end
  endtask

  task automatic test_halt();
    pulse_clear();
    opcode = 4'b1111;
    tick(2);
    total++;
    if (step !== 3'd2 || ctrl !== 16'h8000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL hlt_t2 step=%0d ctrl=%h halted=%b want 2/8000/0", step, ctrl, halted);
    end
    tick(1);
    total++;
    if (halted !== 1'b1 || step !== 3'd2) begin
      bad++;
      $display("FAIL hlt_set halted=%b step=%0d want 1/2", halted, step);
    end
    opcode = 4'b0010;
    tick(10);
    total++;
    if (halted !== 1'b1 || step !== 3'd2 || ctrl !== 16'h8000) begin
      bad++;
      $display("FAIL hlt_frozen halted=%b step=%0d ctrl=%h want 1/2/8000", halted, step, ctrl);
    end
    pulse_clear();
    total++;
    if (halted !== 1'b0 || step !== 3'd0 || ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL hlt_exit halted=%b step=%0d ctrl=%h want 0/0/4004", halted, step, ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_lda();
    test_t2_table();
    test_cond_jump();
    test_run_hold();
    test_clear_mid_add();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5, microsteps per instruction; legal range 5..8.
REQ-002 SHALL have ports `clk`, input, 1: system clock; all state changes on the rising edge.
REQ-003 SHALL have ports `clear`, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have `run`, input, 1: 1 = advance; 0 = hold step for front-panel RAM programming.
REQ-005 SHALL have `opcode`, input, 4: instruction register high nibble.
REQ-006 SHALL have `carry_flag` and `zero_flag`, input, 1 each: registered ALU flags.
REQ-007 SHALL have `ctrl`, output, 16: control word; bit map per REQ-026.
REQ-008 SHALL have `step`, output, 3: current microstep T0..T(NUM_STEPS-1).
REQ-009 SHALL have `halted`, output, 1: HLT executed.

Function
REQ-010 SHALL advance `step` by 1 per rising `clk` when `run`=1 and `halted`=0.
- After T(NUM_STEPS-1), `step` wraps to T0.
REQ-011 SHALL decode `ctrl` combinationally from `step`, `opcode` and the flags; zero added latency within a step.
REQ-012 SHALL drive the fetch steps for every opcode:
- T0 = PC_OUT|MAR_IN
- T1 = RAM_OUT|IR_IN|PC_EN
REQ-013 SHALL drive these execute steps (T2/T3/T4); unlisted steps = 0:
- LDA 0001: IR_OUT|MAR_IN / RAM_OUT|A_IN
- ADD 0010: IR_OUT|MAR_IN / RAM_OUT|B_IN / SUM_OUT|A_IN|FLAGS_IN
- SUB 0011: as ADD, with SUBTRACT added to T4
- STA 0100: IR_OUT|MAR_IN / A_OUT|RAM_IN
- LDI 0101: IR_OUT|A_IN
- JMP 0110: IR_OUT|JUMP
- JC 0111: IR_OUT|JUMP if `carry_flag`=1, else 0
- JZ 1000: IR_OUT|JUMP if `zero_flag`=1, else 0
- OUT 1110: A_OUT|OUT_IN
- HLT 1111: HALT
REQ-014 SHALL treat opcodes 0000 and 1001-1101 as NOP, with fetch steps only.
REQ-015 SHALL set `halted` on the rising edge that ends T2 of HLT.
- Once `halted`=1, `step` freezes at T2 and `ctrl` = HALT only.
- Only `clear` exits this state.
REQ-016 SHALL hold `step` and `ctrl` unchanged while `run`=0.
- `halted` SHALL take precedence over `run`.
REQ-017 SHALL assert at most one bus driver (RAM_OUT, IR_OUT, A_OUT, SUM_OUT, PC_OUT) in any step.
REQ-018 SHALL sample the flags for JC/JZ at T2 only; a flag change inside T2 SHALL update `ctrl` within the same step.

Reset
REQ-019 SHALL, while `clear`=1, force `step`=0, `halted`=0 and `ctrl`=16'h0000, asynchronously.
REQ-020 SHALL, on release of `clear`, present the T0 fetch word without waiting for a clock edge.
REQ-021 SHALL abort any instruction in progress when `clear` asserts; no partial state is retained.

Configuration
REQ-022 SHALL honour macro CTRL_SEQ_EARLY_END_EN.
REQ-023 SHALL, when CTRL_SEQ_EARLY_END_EN is defined, return `step` to T0 on the edge that ends the last non-zero step.
- Cycles per instruction: LDI/JMP/OUT/NOP/untaken JC/JZ = 3; LDA/STA = 4; ADD/SUB = 5.
- NOP and untaken jumps end after T2.
REQ-024 SHALL, when CTRL_SEQ_EARLY_END_EN is undefined, execute all NUM_STEPS steps for every instruction.

Structure
REQ-025 SHALL place opcode constants and control-bit indices in shared package sap_ctrl_pkg.
REQ-026 SHALL use this bit map, from 15 down to 0:
- HALT, MAR_IN, RAM_IN, RAM_OUT, IR_OUT, IR_IN, A_IN, A_OUT
- SUM_OUT, SUBTRACT, B_IN, OUT_IN, PC_EN, PC_OUT, JUMP, FLAGS_IN
REQ-027 SHALL implement the decode of REQ-012..014 as combinational sub-module microcode_rom.
- The step counter and halt latch SHALL remain in control_sequencer.

Verification
REQ-028 SHALL cover: pulse `clear` mid-ADD at T3 -> `step`=0, `ctrl`=0 during `clear`, 16'h4004 after release.
REQ-029 SHALL cover: `opcode`=0010, `run`=1, 5 clocks -> `ctrl` = 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, then wrap to 16'h4004.
REQ-030 SHALL cover: `opcode`=0111 at T2 -> `carry_flag`=1 gives 16'h0802; `carry_flag`=0 gives 16'h0000.
- With CTRL_SEQ_EARLY_END_EN, `step` returns to 0 after 3 clocks.
REQ-031 SHALL cover: `opcode`=1111 -> `halted`=1 after T2; 10 more clocks leave `step`=2 and `ctrl`=16'h8000.
REQ-032 SHALL cover: `run`=0 for 4 clocks at T3 of STA -> `step`=3 and `ctrl`=16'h2100 held; resumes on `run`=1.
